// File: rtl/ct_vfpu_fwd_vreg_src_pkg.sv
// Shared VFPU forwarding definitions: widths and result-latency encoding.
package ct_vfpu_fwd_vreg_src_pkg;

  localparam int unsigned VREG_W = 7;
  localparam int unsigned DATA_W = 64;

  // Stage in which an instruction's result first becomes available.
  typedef enum logic [1:0] {
    LAT_EX3 = 2'd0,
    LAT_EX4 = 2'd1,
    LAT_EX5 = 2'd2
  } lat_e;

  // The raw issue encoding 2'd3 has no stage of its own and behaves as EX5.
  function automatic lat_e lat_decode(input logic [1:0] raw);
    case (raw)
      2'd0:    lat_decode = LAT_EX3;
      2'd1:    lat_decode = LAT_EX4;
      default: lat_decode = LAT_EX5;
    endcase
  endfunction

endpackage

// File: rtl/ct_vfpu_fwd_vreg_src_stage.sv
// One EX4/EX5 slice: valid/vreg/lat tracking plus an early-result buffer
// so an instruction that finished earlier keeps forwarding its data here.
module ct_vfpu_fwd_stage
  import ct_vfpu_fwd_vreg_src_pkg::*;
#(
  parameter int unsigned VREG_W  = ct_vfpu_fwd_vreg_src_pkg::VREG_W,
  parameter int unsigned DATA_W  = ct_vfpu_fwd_vreg_src_pkg::DATA_W,
  parameter lat_e        FWD_LAT = LAT_EX4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [VREG_W-1:0] in_vreg,
  input  lat_e              in_lat,
  input  logic              in_cap,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] dp_result,
  output logic              vld,
  output logic [VREG_W-1:0] vreg,
  output lat_e              lat,
  output logic              fwd_vld,
  output logic [DATA_W-1:0] fwd_data
);

  logic              vld_q, vld_d;
  logic [VREG_W-1:0] vreg_q, vreg_d;
  lat_e              lat_q, lat_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state: fields only load behind a valid instruction, otherwise hold.
  always_comb begin
    vld_d  = in_vld & ~flush;
    vreg_d = vreg_q;
    lat_d  = lat_q;
    rdy_d  = rdy_q;
    data_d = data_q;
    if (in_vld) begin
      vreg_d = in_vreg;
      lat_d  = in_lat;
      rdy_d  = in_cap;
      if (in_cap) begin
        data_d = in_data;
      end
    end
  end

  // Slice registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      vreg_q <= '0;
      lat_q  <= LAT_EX3;
      rdy_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      vreg_q <= vreg_d;
      lat_q  <= lat_d;
      rdy_q  <= rdy_d;
      data_q <= data_d;
    end
  end

  assign vld      = vld_q;
  assign vreg     = vreg_q;
  assign lat      = lat_q;
  assign fwd_vld  = vld_q & (lat_q <= FWD_LAT);
  assign fwd_data = rdy_q ? data_q : dp_result;

endmodule

// File: rtl/ct_vfpu_fwd_vreg_src.sv
// VFPU pipe producer side of the vreg forwarding network (EX3/EX4/EX5).
module ct_vfpu_fwd_vreg_src
  import ct_vfpu_fwd_vreg_src_pkg::*;
#(
  parameter int unsigned VREG_W = ct_vfpu_fwd_vreg_src_pkg::VREG_W,
  parameter int unsigned DATA_W = ct_vfpu_fwd_vreg_src_pkg::DATA_W
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              rtu_yy_xx_flush,
  input  logic              idu_vfpu_rf_pipe_sel,
  input  logic              idu_vfpu_rf_pipe_dst_vld,
  input  logic [VREG_W-1:0] idu_vfpu_rf_pipe_dst_vreg,
  input  logic [1:0]        idu_vfpu_rf_pipe_lat,
  input  logic [DATA_W-1:0] dp_ex3_result,
  input  logic [DATA_W-1:0] dp_ex4_result,
  input  logic [DATA_W-1:0] dp_ex5_result,
  output logic              vfpu_idu_ex3_pipe_fwd_vld,
  output logic [VREG_W-1:0] vfpu_idu_ex3_pipe_fwd_vreg,
  output logic [DATA_W-1:0] vfpu_idu_ex3_pipe_fwd_vreg_data,
  output logic              vfpu_idu_ex4_pipe_fwd_vld,
  output logic [VREG_W-1:0] vfpu_idu_ex4_pipe_fwd_vreg,
  output logic [DATA_W-1:0] vfpu_idu_ex4_pipe_fwd_vreg_data,
  output logic              vfpu_idu_ex5_pipe_fwd_vld,
  output logic [VREG_W-1:0] vfpu_idu_ex5_pipe_fwd_vreg,
  output logic [DATA_W-1:0] vfpu_idu_ex5_pipe_wb_vreg_data,
  output logic              vfpu_rtu_ex5_pipe_wb_vld
);

  logic              ex1_vld_q, ex1_vld_d, ex2_vld_q, ex2_vld_d, ex3_vld_q, ex3_vld_d;
  logic [VREG_W-1:0] ex1_vreg_q, ex1_vreg_d, ex2_vreg_q, ex2_vreg_d, ex3_vreg_q, ex3_vreg_d;
  lat_e              ex1_lat_q, ex1_lat_d, ex2_lat_q, ex2_lat_d, ex3_lat_q, ex3_lat_d;
  logic              issue;

  logic              ex4_vld, ex4_fwd_vld, ex5_vld, ex5_fwd_vld;
  logic [VREG_W-1:0] ex4_vreg, ex5_vreg;
  lat_e              ex4_lat, ex5_lat_unused;
  logic [DATA_W-1:0] ex4_fwd_data, ex5_fwd_data;

  assign issue = idu_vfpu_rf_pipe_sel & idu_vfpu_rf_pipe_dst_vld;

  // EX1..EX3 control: valids shift with flush kill, fields hold when idle.
  always_comb begin
    ex1_vld_d  = issue & ~rtu_yy_xx_flush;
    ex1_vreg_d = ex1_vreg_q;
    ex1_lat_d  = ex1_lat_q;
    if (issue) begin
      ex1_vreg_d = idu_vfpu_rf_pipe_dst_vreg;
      ex1_lat_d  = lat_decode(idu_vfpu_rf_pipe_lat);
    end
    ex2_vld_d  = ex1_vld_q & ~rtu_yy_xx_flush;
    ex2_vreg_d = ex1_vld_q ? ex1_vreg_q : ex2_vreg_q;
    ex2_lat_d  = ex1_vld_q ? ex1_lat_q : ex2_lat_q;
    ex3_vld_d  = ex2_vld_q & ~rtu_yy_xx_flush;
    ex3_vreg_d = ex2_vld_q ? ex2_vreg_q : ex3_vreg_q;
    ex3_lat_d  = ex2_vld_q ? ex2_lat_q : ex3_lat_q;
  end

  // EX1..EX3 control registers.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ex1_vld_q  <= 1'b0;
      ex2_vld_q  <= 1'b0;
      ex3_vld_q  <= 1'b0;
      ex1_vreg_q <= '0;
      ex2_vreg_q <= '0;
      ex3_vreg_q <= '0;
      ex1_lat_q  <= LAT_EX3;
      ex2_lat_q  <= LAT_EX3;
      ex3_lat_q  <= LAT_EX3;
    end else begin
      ex1_vld_q  <= ex1_vld_d;
      ex2_vld_q  <= ex2_vld_d;
      ex3_vld_q  <= ex3_vld_d;
      ex1_vreg_q <= ex1_vreg_d;
      ex2_vreg_q <= ex2_vreg_d;
      ex3_vreg_q <= ex3_vreg_d;
      ex1_lat_q  <= ex1_lat_d;
      ex2_lat_q  <= ex2_lat_d;
      ex3_lat_q  <= ex3_lat_d;
    end
  end

  ct_vfpu_fwd_stage #(
    .VREG_W  (VREG_W),
    .DATA_W  (DATA_W),
    .FWD_LAT (LAT_EX4)
  ) u_ex4 (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .flush     (rtu_yy_xx_flush),
    .in_vld    (ex3_vld_q),
    .in_vreg   (ex3_vreg_q),
    .in_lat    (ex3_lat_q),
    .in_cap    (ex3_lat_q == LAT_EX3),
    .in_data   (dp_ex3_result),
    .dp_result (dp_ex4_result),
    .vld       (ex4_vld),
    .vreg      (ex4_vreg),
    .lat       (ex4_lat),
    .fwd_vld   (ex4_fwd_vld),
    .fwd_data  (ex4_fwd_data)
  );

  // EX5 has no successor, so its lat copy is only used for its own fwd_vld.
  ct_vfpu_fwd_stage #(
    .VREG_W  (VREG_W),
    .DATA_W  (DATA_W),
    .FWD_LAT (LAT_EX5)
  ) u_ex5 (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .flush     (rtu_yy_xx_flush),
    .in_vld    (ex4_vld),
    .in_vreg   (ex4_vreg),
    .in_lat    (ex4_lat),
    .in_cap    (ex4_fwd_vld),
    .in_data   (ex4_fwd_data),
    .dp_result (dp_ex5_result),
    .vld       (ex5_vld),
    .vreg      (ex5_vreg),
    .lat       (ex5_lat_unused),
    .fwd_vld   (ex5_fwd_vld),
    .fwd_data  (ex5_fwd_data)
  );

  assign vfpu_idu_ex3_pipe_fwd_vld       = ex3_vld_q & (ex3_lat_q == LAT_EX3);
  assign vfpu_idu_ex3_pipe_fwd_vreg      = ex3_vreg_q;
  assign vfpu_idu_ex3_pipe_fwd_vreg_data = dp_ex3_result;

  assign vfpu_idu_ex4_pipe_fwd_vld       = ex4_fwd_vld;
  assign vfpu_idu_ex4_pipe_fwd_vreg      = ex4_vreg;
  assign vfpu_idu_ex4_pipe_fwd_vreg_data = ex4_fwd_data;

  // Every lat is at most EX5, so the EX5 forward and writeback valids coincide.
  assign vfpu_idu_ex5_pipe_fwd_vld       = ex5_fwd_vld;
  assign vfpu_idu_ex5_pipe_fwd_vreg      = ex5_vreg;
  assign vfpu_idu_ex5_pipe_wb_vreg_data  = ex5_fwd_data;
  assign vfpu_rtu_ex5_pipe_wb_vld        = ex5_vld;

endmodule
